// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port byte-enabled RAM.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package ram_pkg;

    // Controller states: clear sweep after reset, then normal operation.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Widest word the merge helper supports. Callers widen their operands
    // to this size and cast the result back down to their own DATA_W.
    localparam int MAX_W = 256;
    localparam int MAX_B = MAX_W / 8;

    // Byte merge: for every enabled byte take new_w, otherwise keep old_w.
    // The write path uses it to apply byte enables, and the new-data bypass
    // uses it to build the same word that the write will store.
    function automatic logic [MAX_W-1:0] byte_merge(
        input logic [MAX_W-1:0] old_w,
        input logic [MAX_W-1:0] new_w,
        input logic [MAX_B-1:0] be
    );
        logic [MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MAX_B; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_array.sv
// Plain storage array: byte-enabled synchronous write, asynchronous read.
// Latency: write takes effect at the clock edge; read data is combinational.
// Backpressure: none; every write is accepted. Can be swapped for a vendor macro.
module ram_array
    import ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                clk,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [ADDR_W-1:0]   i_waddr,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [ADDR_W-1:0]   i_raddr,
    output logic [DATA_W-1:0]   o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // The array is deliberately not reset; the top clears it with a sweep.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_wword;

    assign w_wword = DATA_W'(byte_merge(MAX_W'(r_mem[i_waddr]),
                                        MAX_W'(i_wdata),
                                        MAX_B'(i_be)));

    // Store the byte-merged word; disabled bytes are written back unchanged.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= w_wword;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_sdp_be.sv
// Simple-dual-port RAM with byte-enabled writes, registered reads and a post-reset clear sweep.
// Latency: read result 1 cycle after re (2 with OUT_REG=1); sweep lasts 2**ADDR_W cycles.
// Backpressure: none on requests; while busy is high all we/re requests are dropped.
module ram_sdp_be
    import ram_pkg::*;
#(
    parameter int                DATA_W        = 32,
    parameter int                ADDR_W        = 10,
    parameter int                RDW_MODE      = 0,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0,
    parameter int                OUT_REG       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   din,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    if ((DATA_W % 8) != 0 || DATA_W > MAX_W || DATA_W <= 0) begin : g_bad_width
        $error("ram_sdp_be: DATA_W must be a positive multiple of 8 no wider than MAX_W");
    end

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic                r_busy;

    logic                w_run;
    logic                w_wr_en;
    logic                w_rd_en;
    logic                w_arr_we;
    logic [BE_W-1:0]     w_arr_be;
    logic [ADDR_W-1:0]   w_arr_waddr;
    logic [DATA_W-1:0]   w_arr_wdata;
    logic [DATA_W-1:0]   w_arr_rdata;
    logic                w_bypass;
    logic [DATA_W-1:0]   w_rd_word;

    logic [DATA_W-1:0]   r_dout1;
    logic                r_vld1;

    // Sweep controller: INIT walks every address once, then RUN until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
            r_cnt   <= '0;
            r_busy  <= (INIT_ON_RESET != 0);
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {ADDR_W{1'b1}}) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign w_run   = (r_state == ST_RUN);
    assign w_wr_en = w_run & we;
    assign w_rd_en = w_run & re;
    assign busy    = r_busy;

    // During the sweep the array port is owned by the counter, full-word writes.
    assign w_arr_we    = w_run ? w_wr_en : 1'b1;
    assign w_arr_be    = w_run ? be      : {BE_W{1'b1}};
    assign w_arr_waddr = w_run ? waddr   : r_cnt;
    assign w_arr_wdata = w_run ? din     : INIT_VALUE;

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_be    (w_arr_be),
        .i_waddr (w_arr_waddr),
        .i_wdata (w_arr_wdata),
        .i_raddr (raddr),
        .o_rdata (w_arr_rdata)
    );

    // Same-address collision in new-data mode: forward the word being written.
    assign w_bypass  = (RDW_MODE != 0) && w_wr_en && (waddr == raddr);
    assign w_rd_word = w_bypass ? DATA_W'(byte_merge(MAX_W'(w_arr_rdata),
                                                     MAX_W'(din),
                                                     MAX_B'(be)))
                                : w_arr_rdata;

    // First read stage: capture the word on re, hold it otherwise; valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout1 <= '0;
            r_vld1  <= 1'b0;
        end else begin
            r_vld1 <= w_rd_en;
            if (w_rd_en) begin
                r_dout1 <= w_rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_W-1:0] r_dout2;
        logic              r_vld2;

        // Optional output stage: delays data and its valid pulse together.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_dout2 <= '0;
                r_vld2  <= 1'b0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_dout2 <= r_dout1;
                end
            end
        end

        assign dout       = r_dout2;
        assign dout_valid = r_vld2;
    end else begin : g_no_out_reg
        assign dout       = r_dout1;
        assign dout_valid = r_vld1;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: three instances with different modes share one stimulus.
// u0: old-data RDW, no output reg; u1: new-data RDW, output reg; u2: new-data RDW, no sweep.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ram_sdp_be;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  waddr;
    logic [31:0] din;
    logic        re;
    logic [3:0]  raddr;

    logic [31:0] d0, d1, d2;
    logic        v0, v1, v2;
    logic        b0, b1, b2;

    int n_tests;
    int n_fail;

    localparam logic [31:0] IV = 32'hDEADBEEF;

    ram_sdp_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(0), .INIT_ON_RESET(1),
                 .INIT_VALUE(32'hDEADBEEF), .OUT_REG(0)) u0 (
        .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr), .dout(d0), .dout_valid(v0), .busy(b0));

    ram_sdp_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1), .INIT_ON_RESET(1),
                 .INIT_VALUE(32'hDEADBEEF), .OUT_REG(1)) u1 (
        .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr), .dout(d1), .dout_valid(v1), .busy(b1));

    ram_sdp_be #(.DATA_W(32), .ADDR_W(4), .RDW_MODE(1), .INIT_ON_RESET(0),
                 .INIT_VALUE(32'hDEADBEEF), .OUT_REG(0)) u2 (
        .clk(clk), .rst(rst), .we(we), .be(be), .waddr(waddr), .din(din),
        .re(re), .raddr(raddr), .dout(d2), .dout_valid(v2), .busy(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Helper: one-cycle write issued at a falling edge.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
        we = 1'b1; waddr = a; din = d; be = m;
        @(negedge clk);
        we = 1'b0; be = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b0; we = 1'b0; re = 1'b0; be = 4'b0; waddr = '0; raddr = '0; din = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (d0 !== 32'h0 || v0 !== 1'b0 || b0 !== 1'b1) begin n_fail++;
            $display("FAIL reset_u0: dout=%h vld=%b busy=%b, want 0/0/1", d0, v0, b0); end
        n_tests++; if (d1 !== 32'h0 || v1 !== 1'b0 || b1 !== 1'b1) begin n_fail++;
            $display("FAIL reset_u1: dout=%h vld=%b busy=%b, want 0/0/1", d1, v1, b1); end
        n_tests++; if (d2 !== 32'h0 || v2 !== 1'b0 || b2 !== 1'b0) begin n_fail++;
            $display("FAIL reset_u2: dout=%h vld=%b busy=%b, want 0/0/0", d2, v2, b2); end
    endtask

    task automatic test_init_sweep();
        int c0, c1, c2;
        c0 = 0; c1 = 0; c2 = 0;
        rst = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (b0 === 1'b1) c0++;
            if (b1 === 1'b1) c1++;
            if (b2 !== 1'b0) c2++;
            @(negedge clk);
        end
        n_tests++; if (c0 != 16) begin n_fail++;
            $display("FAIL sweep_len_u0: busy cycles=%0d, want 16", c0); end
        n_tests++; if (c1 != 16) begin n_fail++;
            $display("FAIL sweep_len_u1: busy cycles=%0d, want 16", c1); end
        n_tests++; if (c2 != 0) begin n_fail++;
            $display("FAIL no_init_busy_u2: busy cycles=%0d, want 0", c2); end
        for (int a = 0; a < 16; a++) begin
            re = 1'b1; raddr = 4'(a);
            @(negedge clk);
            re = 1'b0;
            n_tests++; if (v0 !== 1'b1 || d0 !== IV) begin n_fail++;
                $display("FAIL init_read_u0[%0d]: vld=%b dout=%h, want 1/%h", a, v0, d0, IV); end
            n_tests++; if (v1 !== 1'b0) begin n_fail++;
                $display("FAIL init_early_u1[%0d]: vld=%b, want 0", a, v1); end
            @(negedge clk);
            n_tests++; if (v1 !== 1'b1 || d1 !== IV || v0 !== 1'b0) begin n_fail++;
                $display("FAIL init_read_u1[%0d]: vld=%b dout=%h u0vld=%b, want 1/%h/0", a, v1, d1, v0, IV); end
        end
    endtask

    task automatic test_byte_enable();
        do_write(4'd5, 32'h11223344, 4'b1111);
        do_write(4'd5, 32'hAABBCCDD, 4'b0101);
        do_write(4'd6, 32'h55667788, 4'b0000);
        re = 1'b1; raddr = 4'd5;
        @(negedge clk);
        raddr = 4'd6;
        n_tests++; if (d0 !== 32'h11BB33DD) begin n_fail++;
            $display("FAIL be_merge_u0: dout=%h, want 11bb33dd", d0); end
        n_tests++; if (d2 !== 32'h11BB33DD) begin n_fail++;
            $display("FAIL be_merge_u2: dout=%h, want 11bb33dd", d2); end
        @(negedge clk);
        re = 1'b0;
        n_tests++; if (d1 !== 32'h11BB33DD) begin n_fail++;
            $display("FAIL be_merge_u1: dout=%h, want 11bb33dd", d1); end
        n_tests++; if (d0 !== IV) begin n_fail++;
            $display("FAIL be_zero_noop_u0: dout=%h, want %h", d0, IV); end
        @(negedge clk);
        n_tests++; if (d1 !== IV) begin n_fail++;
            $display("FAIL be_zero_noop_u1: dout=%h, want %h", d1, IV); end
    endtask

    task automatic test_rdw();
        do_write(4'd3, 32'h0, 4'b1111);
        we = 1'b1; waddr = 4'd3; din = 32'hCAFEF00D; be = 4'b1111;
        re = 1'b1; raddr = 4'd3;
        @(negedge clk);
        we = 1'b0; re = 1'b0; be = 4'b0;
        n_tests++; if (v0 !== 1'b1 || d0 !== 32'h0) begin n_fail++;
            $display("FAIL rdw_old_u0: vld=%b dout=%h, want 1/00000000", v0, d0); end
        n_tests++; if (v2 !== 1'b1 || d2 !== 32'hCAFEF00D) begin n_fail++;
            $display("FAIL rdw_new_u2: vld=%b dout=%h, want 1/cafef00d", v2, d2); end
        @(negedge clk);
        n_tests++; if (v1 !== 1'b1 || d1 !== 32'hCAFEF00D) begin n_fail++;
            $display("FAIL rdw_new_u1: vld=%b dout=%h, want 1/cafef00d", v1, d1); end
        re = 1'b1; raddr = 4'd3;
        @(negedge clk);
        re = 1'b0;
        n_tests++; if (d0 !== 32'hCAFEF00D || d2 !== 32'hCAFEF00D) begin n_fail++;
            $display("FAIL rdw_after: u0=%h u2=%h, want cafef00d", d0, d2); end
        @(negedge clk);
        n_tests++; if (d1 !== 32'hCAFEF00D) begin n_fail++;
            $display("FAIL rdw_after_u1: dout=%h, want cafef00d", d1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [3];
        logic        e0, e1;
        vals[0] = 32'hA0A0_0000; vals[1] = 32'hA1A1_1111; vals[2] = 32'hA2A2_2222;
        for (int i = 0; i < 3; i++) do_write(4'(i), vals[i], 4'b1111);
        @(negedge clk);
        @(negedge clk);
        for (int t = 0; t < 6; t++) begin
            e0 = (t >= 1 && t <= 3);
            e1 = (t >= 2 && t <= 4);
            n_tests++; if (v0 !== e0 || (e0 && d0 !== vals[t-1])) begin n_fail++;
                $display("FAIL b2b_u0[t%0d]: vld=%b dout=%h, want vld %b", t, v0, d0, e0); end
            n_tests++; if (v1 !== e1 || (e1 && d1 !== vals[t-2])) begin n_fail++;
                $display("FAIL b2b_u1[t%0d]: vld=%b dout=%h, want vld %b", t, v1, d1, e1); end
            re = (t < 3); raddr = 4'(t);
            @(negedge clk);
        end
        re = 1'b0;
    endtask

    task automatic test_hold();
        do_write(4'd7, 32'h12345678, 4'b1111);
        re = 1'b1; raddr = 4'd7;
        @(negedge clk);
        re = 1'b0; raddr = 4'd0;
        @(negedge clk);
        @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            n_tests++; if (d0 !== 32'h12345678 || v0 !== 1'b0) begin n_fail++;
                $display("FAIL hold_u0[%0d]: dout=%h vld=%b, want 12345678/0", t, d0, v0); end
            n_tests++; if (d1 !== 32'h12345678 || v1 !== 1'b0) begin n_fail++;
                $display("FAIL hold_u1[%0d]: dout=%h vld=%b, want 12345678/0", t, d1, v1); end
            n_tests++; if (d2 !== 32'h12345678 || v2 !== 1'b0) begin n_fail++;
                $display("FAIL hold_u2[%0d]: dout=%h vld=%b, want 12345678/0", t, d2, v2); end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_gating();
        int c0, c1, pv;
        c0 = 0; c1 = 0; pv = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        we = 1'b1; waddr = 4'd9; din = 32'h0BAD0BAD; be = 4'b1111;
        re = 1'b1; raddr = 4'd9;
        for (int t = 0; t < 7; t++) begin
            if (v0 !== 1'b0 || v1 !== 1'b0) pv++;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (b0 === 1'b1) c0++;
            if (b1 === 1'b1) c1++;
            if (v0 !== 1'b0 || v1 !== 1'b0) pv++;
            if (b0 !== 1'b1 && b1 !== 1'b1) begin
                we = 1'b0; re = 1'b0; be = 4'b0;
            end
            @(negedge clk);
        end
        we = 1'b0; re = 1'b0;
        n_tests++; if (c0 != 16 || c1 != 16) begin n_fail++;
            $display("FAIL midsweep_len: busy u0=%0d u1=%0d, want 16", c0, c1); end
        n_tests++; if (pv != 0) begin n_fail++;
            $display("FAIL busy_no_valid: pulses=%0d, want 0", pv); end
        re = 1'b1; raddr = 4'd9;
        @(negedge clk);
        re = 1'b0;
        n_tests++; if (v0 !== 1'b1 || d0 !== IV) begin n_fail++;
            $display("FAIL busy_no_write_u0: vld=%b dout=%h, want 1/%h", v0, d0, IV); end
        @(negedge clk);
        n_tests++; if (v1 !== 1'b1 || d1 !== IV) begin n_fail++;
            $display("FAIL busy_no_write_u1: vld=%b dout=%h, want 1/%h", v1, d1, IV); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_init_sweep();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_hold();
        test_busy_gating();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
Parametrised simple-dual-port RAM; successor to the team's single-port 1024x32 block. Provides:
- one write port with per-byte enables;
- one independent read port with a registered read and a read-valid strobe;
- a selectable read-during-write mode;
- a post-reset sweep that writes INIT_VALUE into every word.

It sits between the datapath and the bus as general-purpose scratch/data memory.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8
ADDR_W, 10, address width; depth is 2**ADDR_W words
RDW_MODE, 0, same-address read during write: 0 returns old data, 1 returns new (merged) data
INIT_ON_RESET, 1, 1 runs the clear sweep after reset; 0 goes straight to RUN
INIT_VALUE, 0, DATA_W-bit value written to every word during the sweep
OUT_REG, 0, 1 adds one output pipeline stage (read latency 2 instead of 1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
we  in  1  write request
be  in  DATA_W/8  byte enables for write; bit i covers din[8i+7:8i]
waddr  in  ADDR_W  write address
din  in  DATA_W  write data
re  in  1  read request
raddr  in  ADDR_W  read address
dout  out  DATA_W  read data, held until next completed read
dout_valid  out  1  one-cycle pulse when dout carries a new read result
busy  out  1  high while the init sweep runs; requests ignored

Behaviour:
- Reset (async assert, sync use on deassert):
  - State = INIT if INIT_ON_RESET=1, else RUN.
  - Sweep counter = 0; dout = 0; dout_valid = 0; busy = INIT_ON_RESET; any OUT_REG stage registers = 0.
  - The array itself is not reset.
- FSM states INIT and RUN:
  - INIT: each cycle writes INIT_VALUE to mem[cnt] with all bytes enabled; cnt++.
  - On cnt = 2**ADDR_W-1 the last word is written that cycle; next state is RUN and busy falls in the same edge.
  - Sweep length is exactly 2**ADDR_W cycles from the first clock after rst deasserts.
  - RUN is terminal until the next reset.
  - Reset asserted mid-sweep restarts the sweep at address 0.
- While busy: we and re are ignored; no array write from the ports; dout_valid stays 0; dout holds 0.
- Write (RUN, we=1): for each i with be[i]=1, mem[waddr] byte i := din byte i. Bytes with be[i]=0 are unchanged. we=1 with be=0 is a no-op.
- Read (RUN, re=1):
  - OUT_REG=0: at edge k, dout := read result and dout_valid=1 during cycle k+1 only.
  - OUT_REG=1: result is presented one edge later (latency 2) with the valid pulse aligned to it.
  - Back-to-back reads every cycle give one result per cycle, in order.
  - With re=0, dout holds its value and dout_valid=0.
- Simultaneous read and write, raddr != waddr: independent; both complete.
- Simultaneous read and write, raddr == waddr:
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns the merged word (enabled bytes from din, others from old content).
- Addresses wrap naturally; every ADDR_W value is a valid location.
- Width rules: be width = DATA_W/8. Implementations are rejected at elaboration if DATA_W%8 != 0.

Decomposition:
- Shared package ram_pkg:
  - state encoding (ST_INIT, ST_RUN);
  - a function computing the byte-merge of old word, din and be (used by both the write path and RDW_MODE=1 bypass).
- Sub-module ram_array: the plain storage array with byte-enabled write and unregistered read, so the FSM, bypass and output pipeline stay in the top and the array can be swapped for a vendor macro.

Test Plan:
- Init sweep (ADDR_W=4, INIT_VALUE=32'hDEADBEEF, INIT_ON_RESET=1):
  - Release rst → busy=1 for exactly 16 cycles, then 0.
  - Subsequent reads of addresses 0..15 → dout=DEADBEEF each, dout_valid one cycle after each re.
- Byte enables:
  - Write 32'h11223344 be=4'b1111 to addr 5, then 32'hAABBCCDD be=4'b0101 to addr 5.
  - Read addr 5 → 32'h11BB33DD.
- Read-during-write, write 32'hCAFEF00D to addr 3 (old content 0) with re, raddr=3 in the same cycle:
  - RDW_MODE=0 → dout=0.
  - RDW_MODE=1 → dout=CAFEF00D.
  - Next read of addr 3 → CAFEF00D in both modes.
- Latency and throughput:
  - OUT_REG=0: read 0,1,2 back-to-back → dout_valid high 3 consecutive cycles starting 1 cycle after first re, data in order.
  - OUT_REG=1: same sequence starting 2 cycles after first re.
- Busy gating and mid-sweep reset:
  - Assert we/re during the sweep → no valid pulse; the address targeted retains INIT_VALUE afterwards.
  - Pulse rst at sweep cycle 7 → busy stays high a full 16 cycles after release.
- Hold behaviour:
  - After a read returning 32'h12345678, idle 10 cycles with re=0 → dout remains 12345678, dout_valid=0.
  - INIT_ON_RESET=0: busy=0 immediately after reset.
